systolic_skew_buffer: RTL

- Synthesizable, parametrised skew/deskew delay line for the CORDIC systolic QR array.
- In SKEW mode it staggers NUM_CH parallel input columns so each column reaches its array column aligned with the CORDIC pipeline wavefront.
- In DESKEW mode it applies the complementary delays to realign the array outputs into one row.
- Adds per-channel valid tracking, a global shift-enable (stall), and an in-flight Busy flag.

---
 rtl/systolic_skew_buffer.sv | 65 ++++++
 1 files changed

// File: rtl/systolic_skew_buffer.sv
// Skew/deskew delay line for the CORDIC systolic QR array: per-channel data and valid
// shift lines, global shift enable, in-flight Busy. Optional build macro: SKEW_ZERO_FILL_EN.
module systolic_skew_buffer #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 20,
    parameter int unsigned PIPE_STAGE = 8,
    parameter int unsigned MODE       = 0
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     InEn,
    input  logic                     InValid,
    input  logic [NUM_CH*DATA_W-1:0] InData,
    output logic [NUM_CH-1:0]        OutValid,
    output logic [NUM_CH*DATA_W-1:0] OutData,
    output logic                     Busy
);

    function automatic int unsigned skew_delay(input int unsigned c);
        int unsigned d;
        d = c + 1;
        if (c > 0) d = d + (c - 1) * PIPE_STAGE;
        return d;
    endfunction

    localparam int unsigned DMAX = skew_delay(NUM_CH - 1);

    logic [NUM_CH-1:0] ch_busy;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // Deskew delays complement the skew so that every channel totals DMAX+1.
        localparam int unsigned DLY = (MODE == 0) ? skew_delay(c) : DMAX + 1 - skew_delay(c);

        logic [DATA_W-1:0] dline [DLY];
        logic [DLY-1:0]    vline;
        logic [DATA_W-1:0] din;

`ifdef SKEW_ZERO_FILL_EN
        assign din = InValid ? InData[c*DATA_W +: DATA_W] : '0;
`else
        assign din = InData[c*DATA_W +: DATA_W];
`endif

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                vline <= '0;
                for (int unsigned i = 0; i < DLY; i++) dline[i] <= '0;
            end else if (InEn) begin
                vline[0] <= InValid;
                dline[0] <= din;
                for (int unsigned i = 1; i < DLY; i++) begin
                    vline[i] <= vline[i-1];
                    dline[i] <= dline[i-1];
                end
            end
        end

        assign OutValid[c]                  = vline[DLY-1];
        assign OutData[c*DATA_W +: DATA_W] = dline[DLY-1];
        assign ch_busy[c]                   = |vline;
    end

    assign Busy = |ch_busy;

endmodule
